if_stage_fetch: RTL and testbench
=================================

Name: if_stage_fetch

Overview:
- Instruction-fetch stage directly upstream of the 128-word instruction memory.
- Owns the program counter and drives the memory's byte address.
- Captures the returned instruction, together with PC+4, into the IF/ID pipeline register.
- Handles pipeline stall, IF/ID flush and branch/jump redirect from the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word inserted as a bubble.

Ports:
- Clk, input, 1, rising-edge clock.
- Reset, input, 1, synchronous, active-low reset.
- Stall, input, 1, hold PC and IF/ID contents (load-use hazard).
- Flush, input, 1, replace IF/ID contents with a bubble.
- RedirectValid, input, 1, branch/jump taken; load RedirectPC.
- RedirectPC, input, 32, target byte address.
- ImemAddress, output, 32, byte address to instruction memory; equals PC.
- ImemInstruction, input, 32, combinational read data from instruction memory.
- PC, output, 32, current fetch PC.
- IfIdInstruction, output, 32, registered instruction.
- IfIdPCPlus4, output, 32, registered PC+4 of that instruction.
- IfIdValid, output, 1, 1 when IfIdInstruction is real, 0 when it is a bubble.

Behaviour:
- All state updates on the rising edge of Clk.
- ImemAddress = PC, combinational. Memory read is combinational, so the instruction fetched in cycle N is present at the IF/ID outputs in cycle N+1 (1-cycle latency).
- Reset (Reset==0 at the edge), highest priority:
  - PC <= RESET_PC
  - IfIdInstruction <= NOP_WORD, IfIdPCPlus4 <= 0, IfIdValid <= 0
  - Stall, Flush and Redirect are ignored.
  - Reset asserted mid-operation discards any in-flight instruction.
- PC update priority, Reset > RedirectValid > Stall > normal:
  - Redirect: PC <= {RedirectPC[31:2], 2'b00}. Misaligned low bits are silently dropped.
  - Stall: PC holds.
  - Normal: PC <= PC + 4, modulo 2^32. Wrap 32'hFFFF_FFFC -> 0 is legal. Memory index wrap (bits [8:2]) is memory-side, not checked here.
- IF/ID update priority, Reset > (RedirectValid or Flush) > Stall > normal:
  - Redirect or Flush: bubble (NOP_WORD, PCPlus4 <= 0, Valid <= 0).
  - Stall: hold all three fields.
  - Normal: IfIdInstruction <= ImemInstruction, IfIdPCPlus4 <= PC + 4, IfIdValid <= 1.
- Simultaneous events:
  - Stall & Redirect: redirect wins on both PC and IF/ID.
  - Stall & Flush (no redirect): PC holds and IF/ID becomes a bubble.
  - Flush alone: PC still advances.
- No state machine beyond the PC and IF/ID registers. The block is always fetching.
- First cycle after reset release: ImemAddress = RESET_PC, IfIdValid = 0.

Optional Feature:
- Macro: IF_STAGE_PERF_CNT_EN.
- When defined, adds three outputs, each 32 bits, each reset to 0 and wrapping at 2^32:
  - FetchCount: increments on every normal IF/ID load.
  - StallCount: increments on every cycle with Stall=1, RedirectValid=0 and Reset=1.
  - FlushCount: increments on every cycle with (Flush | RedirectValid)=1 and Reset=1.
- When undefined, the ports and counters are absent. Core behaviour is identical in both cases.

Decomposition:
- Shared package pipeline_pkg holds:
  - NOP_WORD
  - instruction width (32), PC increment (4)
  - the IF/ID struct/bundle layout: instruction, pcplus4, valid.
- One natural sub-module: if_id_reg, the IF/ID register with stall/flush/reset priority. It is reused pattern-wise by later ID/EX and EX/MEM registers.
- PC logic stays in the top module.

Test Plan:
- Reset then straight-line fetch:
  - Stimulus: Reset=0 for 2 cycles, release, memory holds addi $t0,$zero,100 at word 1.
  - Response: PC 0,4,8; in cycle 2 after release IfIdInstruction=32'h2008_0064, IfIdPCPlus4=8, IfIdValid=1.
- Stall:
  - Stimulus: Stall=1 for 3 cycles with PC=12.
  - Response: PC stays 12; IF/ID holds the previous word and PCPlus4=12; once Stall drops, PC=16 the next cycle.
- Redirect:
  - Stimulus: RedirectValid=1 with RedirectPC=32'h0000_0029 at PC=20.
  - Response: next PC=32'h28; IF/ID is a bubble (0, 0, Valid 0); the following cycle fetches from address 0x28.
- Simultaneous Stall+Flush, then Stall+Redirect:
  - Stall+Flush response: PC holds and IF/ID is a bubble.
  - Stall+Redirect (RedirectPC=0x40) response: PC=0x40 and IF/ID is a bubble.
- Wrap and mid-run reset:
  - Force PC=32'hFFFF_FFFC and advance -> PC=0, IfIdPCPlus4=0 with Valid=1.
  - Assert Reset during a stall -> PC=RESET_PC and IfIdValid=0 on the next edge.
- With IF_STAGE_PERF_CNT_EN defined:
  - Stimulus: 10 normal cycles, 3 stall cycles, 2 redirect cycles.
  - Response: FetchCount=10, StallCount=3, FlushCount=2.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants.
// Used by the fetch stage and later pipeline registers.
package pipeline_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pcplus4;
    logic            valid;
  } if_id_t;

  function automatic if_id_t bubble(
    input logic [XLEN-1:0] nop
  );
    if_id_t b;
    b.instruction = nop;
    b.pcplus4     = '0;
    b.valid       = 1'b0;
    return b;
  endfunction

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] addr
  );
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_stage_fetch_if.sv
// Fetch-stage bus: instruction memory port
// plus the IF/ID register outputs.
interface if_stage_fetch_if;

  logic [31:0] ImemAddress;
  logic [31:0] ImemInstruction;
  logic [31:0] IfIdInstruction;
  logic [31:0] IfIdPCPlus4;
  logic        IfIdValid;

  modport master (
    output ImemAddress,
    input  ImemInstruction,
    output IfIdInstruction,
    output IfIdPCPlus4,
    output IfIdValid
  );

  modport slave (
    input  ImemAddress,
    output ImemInstruction,
    input  IfIdInstruction,
    input  IfIdPCPlus4,
    input  IfIdValid
  );

endinterface

// File: rtl/if_stage_fetch_if_id_reg.sv
// IF/ID pipeline register.
// Priority: reset > flush > stall > load.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter logic [31:0] NOP = 32'h0000_0000
) (
  input  logic   Clk,
  input  logic   Reset,
  input  logic   i_stall,
  input  logic   i_flush,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  // bubble on reset/flush, hold on stall, else load
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_q <= bubble(NOP);
    end else if (i_flush) begin
      r_q <= bubble(NOP);
    end else if (!i_stall) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/if_stage_fetch.sv
// Instruction fetch stage: PC + IF/ID register.
// Optional perf counters: IF_STAGE_PERF_CNT_EN.
module if_stage_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD =
    pipeline_pkg::NOP_WORD
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectPC,
  if_stage_fetch_if.master bus,
  output logic [31:0] PC
`ifdef IF_STAGE_PERF_CNT_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
`endif
);

  import pipeline_pkg::*;

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_pc;
  logic        w_flush;
  if_id_t      w_ifid_d;
  if_id_t      w_ifid_q;

  assign w_pc_plus4    = r_pc + PC_INC;
  assign w_redirect_pc = word_align(RedirectPC);
  assign w_flush       = Flush | RedirectValid;

  // PC: reset > redirect > stall > advance
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_pc <= RESET_PC;
    end else if (RedirectValid) begin
      r_pc <= w_redirect_pc;
    end else if (!Stall) begin
      r_pc <= w_pc_plus4;
    end
  end

  assign w_ifid_d.instruction = bus.ImemInstruction;
  assign w_ifid_d.pcplus4     = w_pc_plus4;
  assign w_ifid_d.valid       = 1'b1;

  if_id_reg #(
    .NOP (NOP_WORD)
  ) u_if_id_reg (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_stall (Stall),
    .i_flush (w_flush),
    .i_d     (w_ifid_d),
    .o_q     (w_ifid_q)
  );

  assign bus.ImemAddress     = r_pc;
  assign bus.IfIdInstruction = w_ifid_q.instruction;
  assign bus.IfIdPCPlus4     = w_ifid_q.pcplus4;
  assign bus.IfIdValid       = w_ifid_q.valid;
  assign PC                  = r_pc;

`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
  logic        w_fetch_ev;
  logic        w_stall_ev;

  assign w_fetch_ev = !w_flush && !Stall;
  assign w_stall_ev = Stall && !RedirectValid;

  // event counters, cleared by reset, free-wrapping
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_fetch_ev) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_stall_ev) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush)    r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign FetchCount = r_fetch_cnt;
  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;
`endif

endmodule

// File: tb/tb_if_stage_fetch.sv
// Scoreboard bench for if_stage_fetch.
// Directed vectors, negedge monitor.
module tb_if_stage_fetch;

  logic        Clk;
  logic        Reset;
  logic        Stall;
  logic        Flush;
  logic        RedirectValid;
  logic [31:0] RedirectPC;
  logic [31:0] PC;
`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] FetchCount;
  logic [31:0] StallCount;
  logic [31:0] FlushCount;
`endif

  if_stage_fetch_if bus ();

  logic [31:0] mem [128];

  assign bus.ImemInstruction = mem[bus.ImemAddress[8:2]];

  if_stage_fetch dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Stall         (Stall),
    .Flush         (Flush),
    .RedirectValid (RedirectValid),
    .RedirectPC    (RedirectPC),
    .bus           (bus),
    .PC            (PC)
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    .FetchCount    (FetchCount),
    .StallCount    (StallCount),
    .FlushCount    (FlushCount)
`endif
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    int          idx;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] p4;
    logic        v;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  vec_t m_e;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic add(
    input logic        rst,
    input logic        stall,
    input logic        flush,
    input logic        rv,
    input logic [31:0] rpc,
    input logic [31:0] pc,
    input logic [31:0] ins,
    input logic [31:0] p4,
    input logic        v
  );
    vec_t t;
    t.idx   = vecs.size();
    t.rst   = rst;
    t.stall = stall;
    t.flush = flush;
    t.rv    = rv;
    t.rpc   = rpc;
    t.pc    = pc;
    t.ins   = ins;
    t.p4    = p4;
    t.v     = v;
    vecs.push_back(t);
  endtask

  task automatic chk32(
    input string       name,
    input int          idx,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL v%0d %s: got %h expected %h",
                  idx, name, got, exp);
  endtask

  // monitor: compare DUT state after each edge
  always @(negedge Clk) begin
    if (sb.size() != 0) begin
      m_e = sb.pop_front();
      chk32("pc", m_e.idx, PC, m_e.pc);
      chk32("imem_addr", m_e.idx,
            bus.ImemAddress, m_e.pc);
      chk32("ifid_ins", m_e.idx,
            bus.IfIdInstruction, m_e.ins);
      chk32("ifid_p4", m_e.idx,
            bus.IfIdPCPlus4, m_e.p4);
      chk32("ifid_valid", m_e.idx,
            {31'd0, bus.IfIdValid}, {31'd0, m_e.v});
`ifdef IF_STAGE_PERF_CNT_EN
      if (m_e.idx == 19) begin
        chk32("fetch_cnt", m_e.idx, FetchCount, 32'd10);
        chk32("stall_cnt", m_e.idx, StallCount, 32'd4);
        chk32("flush_cnt", m_e.idx, FlushCount, 32'd5);
      end
      if (m_e.idx == 22) begin
        chk32("fetch_cnt", m_e.idx, FetchCount, 32'd1);
        chk32("stall_cnt", m_e.idx, StallCount, 32'd0);
        chk32("flush_cnt", m_e.idx, FlushCount, 32'd0);
      end
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++)
      mem[i] = 32'h1000_0000 + i;
    mem[1] = 32'h2008_0064;

    //  rst st fl rv rpc            pc             ins            p4             v
    add(0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0,         0);
    add(0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0,         0);
    add(1, 0, 0, 0, 32'h0,         32'h4,         32'h1000_0000, 32'h4,         1);
    add(1, 0, 0, 0, 32'h0,         32'h8,         32'h2008_0064, 32'h8,         1);
    add(1, 0, 0, 0, 32'h0,         32'hC,         32'h1000_0002, 32'hC,         1);
    add(1, 1, 0, 0, 32'h0,         32'hC,         32'h1000_0002, 32'hC,         1);
    add(1, 1, 0, 0, 32'h0,         32'hC,         32'h1000_0002, 32'hC,         1);
    add(1, 1, 0, 0, 32'h0,         32'hC,         32'h1000_0002, 32'hC,         1);
    add(1, 0, 0, 0, 32'h0,         32'h10,        32'h1000_0003, 32'h10,        1);
    add(1, 0, 0, 0, 32'h0,         32'h14,        32'h1000_0004, 32'h14,        1);
    add(1, 0, 0, 1, 32'h29,        32'h28,        32'h0,         32'h0,         0);
    add(1, 0, 0, 0, 32'h0,         32'h2C,        32'h1000_000A, 32'h2C,        1);
    add(1, 0, 1, 0, 32'h0,         32'h30,        32'h0,         32'h0,         0);
    add(1, 0, 0, 0, 32'h0,         32'h34,        32'h1000_000C, 32'h34,        1);
    add(1, 1, 1, 0, 32'h0,         32'h34,        32'h0,         32'h0,         0);
    add(1, 1, 0, 1, 32'h40,        32'h40,        32'h0,         32'h0,         0);
    add(1, 0, 0, 0, 32'h0,         32'h44,        32'h1000_0010, 32'h44,        1);
    add(1, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0,         32'h0,         0);
    add(1, 0, 0, 0, 32'h0,         32'h0,         32'h1000_007F, 32'h0,         1);
    add(1, 0, 0, 0, 32'h0,         32'h4,         32'h1000_0000, 32'h4,         1);
    add(0, 1, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0,         0);
    add(0, 0, 1, 1, 32'h80,        32'h0,         32'h0,         32'h0,         0);
    add(1, 0, 0, 0, 32'h0,         32'h4,         32'h1000_0000, 32'h4,         1);

    Reset         = 1'b0;
    Stall         = 1'b0;
    Flush         = 1'b0;
    RedirectValid = 1'b0;
    RedirectPC    = '0;

    foreach (vecs[k]) begin
      Reset         = vecs[k].rst;
      Stall         = vecs[k].stall;
      Flush         = vecs[k].flush;
      RedirectValid = vecs[k].rv;
      RedirectPC    = vecs[k].rpc;
      @(posedge Clk);
      #1;
      sb.push_back(vecs[k]);
    end

    Stall = 1'b1;
    for (int w = 0; w < 4 && sb.size() != 0; w++)
      @(negedge Clk);
    #1;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0",
                  sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
